reg_file_2r1w: RTL and testbench

// Parametrised register file: 2**W entries of B bits, one write port, two asynchronous read ports.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_clear_ctrl.sv | 56 +++++
 rtl/reg_file_2r1w.sv | 74 +++++++
 tb/tb_reg_file_2r1w.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types for the 2R1W register file.
//   clr_state_e : clear-sequencer FSM state (ST_IDLE, ST_CLEAR)
//   ST_W        : width of the state register
//   NUM_RD      : number of read ports on the file
package reg_file_pkg;

  localparam int ST_W   = 1;
  localparam int NUM_RD = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// reg_file_clear_ctrl: clear sequencer for the register file.
// Sweeps every entry to zero after reset or on a clr request, one entry per edge.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  synchronous active-high reset; restarts the sweep at entry 0
//   clr      in  clear request, sampled only while idle
//   busy     out sweep in progress (decoded from the state register)
//   clr_we   out write-zero strobe for the storage array
//   clr_addr out entry being zeroed this cycle
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic         busy,
  output logic         clr_we,
  output logic [W-1:0] clr_addr
);

  clr_state_e   state;
  logic [W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          // ptr wraps back to 0 on the last entry, so IDLE always sees ptr==0
          ptr <= ptr + 1'b1;
          if (&ptr) state <= ST_IDLE;
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == ST_CLEAR);
  // While reset is held the sweep is parked at entry 0; zeroing starts on release
  assign clr_we   = busy & ~reset;
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2**W x B register file, one write port, two combinational read ports.
// A clear sequencer zeroes the whole array after reset or on request; while it
// runs, user writes are ignored and both read ports return 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clr               clear request (honoured only when idle)
//   wr_en/w_addr/w_data  write port
//   r0_addr/r0_data   read port 0 (combinational)
//   r1_addr/r1_data   read port 1 (combinational)
//   busy              clear sequence in progress
// Parameters: BYPASS forwards a same-cycle write to matching reads;
//             R0_ZERO hardwires entry 0 to zero.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int B       = 8,
  parameter int W       = 2,
  parameter bit BYPASS  = 1'b1,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r0_addr,
  input  logic [W-1:0] r1_addr,
  output logic [B-1:0] r0_data,
  output logic [B-1:0] r1_data,
  output logic         busy
);

  localparam int N = 2 ** W;

  logic [N-1:0][B-1:0]      mem;
  logic                     clr_we;
  logic [W-1:0]             clr_addr;
  logic                     user_we;
  logic                     w_is_r0;
  logic [NUM_RD-1:0][W-1:0] ra;
  logic [NUM_RD-1:0][B-1:0] rd;

  reg_file_clear_ctrl #(.W(W)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign w_is_r0 = R0_ZERO && (w_addr == '0);
  // A clr or reset edge, or an active sweep, swallows the user write
  assign user_we = wr_en & ~clr & ~busy & ~reset & ~w_is_r0;

  always_ff @(posedge clk) begin
    if (clr_we)       mem[clr_addr] <= '0;
    else if (user_we) mem[w_addr]   <= w_data;
  end

  assign ra      = {r1_addr, r0_addr};
  assign r0_data = rd[0];
  assign r1_data = rd[1];

  // Priority: sweep gating, hardwired zero, same-cycle forward, stored value
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd[p] = busy                                        ? '0     :
                   (R0_ZERO && ra[p] == '0)                    ? '0     :
                   (BYPASS && wr_en && !clr && ra[p] == w_addr) ? w_data :
                                                                 mem[ra[p]];
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, clr, wr_en;
  logic [1:0] w_addr, r0_addr, r1_addr;
  logic [7:0] w_data;
  logic [7:0] a_r0, a_r1, n_r0, n_r1, z_r0, z_r1;
  logic       a_busy, n_busy, z_busy;

  always #5 clk = ~clk;

  reg_file_2r1w #(.B(8), .W(2), .BYPASS(1'b1), .R0_ZERO(1'b0)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(a_r0), .r1_data(a_r1), .busy(a_busy));
  reg_file_2r1w #(.B(8), .W(2), .BYPASS(1'b0), .R0_ZERO(1'b0)) dut_n (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(n_r0), .r1_data(n_r1), .busy(n_busy));
  reg_file_2r1w #(.B(8), .W(2), .BYPASS(1'b1), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(z_r0), .r1_data(z_r1), .busy(z_busy));

  int checks = 0;
  int failures = 0;

  // Reference model: config 0 = bypass, 1 = no bypass, 2 = bypass + zero entry 0
  logic [7:0] m [3][N];
  int         busy_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input int c, input logic [1:0] a);
    if (busy_left > 0) return 8'h00;
    if (c == 2 && a == 2'd0) return 8'h00;
    if (c != 1 && wr_en && !clr && a == w_addr) return w_data;
    return m[c][a];
  endfunction

  task automatic check_model();
    chk("busy_a", a_busy, busy_left > 0);
    chk("busy_n", n_busy, busy_left > 0);
    chk("busy_z", z_busy, busy_left > 0);
    chk("a_r0", a_r0, mread(0, r0_addr));
    chk("a_r1", a_r1, mread(0, r1_addr));
    chk("n_r0", n_r0, mread(1, r0_addr));
    chk("n_r1", n_r1, mread(1, r1_addr));
    chk("z_r0", z_r0, mread(2, r0_addr));
    chk("z_r1", z_r1, mread(2, r1_addr));
  endtask

  // Advance the model by one edge using the inputs currently applied, then clock the DUTs.
  task automatic tick();
    if (reset) begin
      busy_left = N;
    end else if (busy_left > 0) begin
      for (int c = 0; c < 3; c++) m[c][N - busy_left] = 8'h00;
      busy_left--;
    end else if (clr) begin
      busy_left = N;
    end else if (wr_en) begin
      m[0][w_addr] = w_data;
      m[1][w_addr] = w_data;
      if (w_addr != 2'd0) m[2][w_addr] = w_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rs, input logic c, input logic we, input logic [1:0] wa,
                       input logic [7:0] wd, input logic [1:0] ra0, input logic [1:0] ra1);
    reset = rs; clr = c; wr_en = we; w_addr = wa; w_data = wd; r0_addr = ra0; r1_addr = ra1;
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rs, c, we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra0, ra1;
    logic       eb;
    logic [7:0] e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic c, input logic we, input logic [1:0] wa,
                              input logic [7:0] wd, input logic [1:0] ra0, input logic [1:0] ra1,
                              input logic eb, input logic [7:0] e0, input logic [7:0] e1);
    vec_t v;
    v.rs = rs; v.c = c; v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.eb = eb; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  vec_t tbl [19];
  int   cnt;

  initial begin
    for (int c = 0; c < 3; c++) for (int a = 0; a < N; a++) m[c][a] = 8'h00;

    // Expected values are for the bypass / no-zero-entry instance.
    tbl[0]  = mk(0,0,0,2'd0,8'h00,2'd0,2'd1, 1,8'h00,8'h00); // sweep edge 1
    tbl[1]  = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 1,8'h00,8'h00);
    tbl[2]  = mk(0,0,0,2'd0,8'h00,2'd0,2'd1, 1,8'h00,8'h00);
    tbl[3]  = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 1,8'h00,8'h00); // sweep edge 4
    tbl[4]  = mk(0,0,0,2'd0,8'h00,2'd0,2'd1, 0,8'h00,8'h00);
    tbl[5]  = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 0,8'h00,8'h00);
    tbl[6]  = mk(0,0,1,2'd2,8'hA5,2'd0,2'd1, 0,8'h00,8'h00);
    tbl[7]  = mk(0,0,1,2'd3,8'h3C,2'd2,2'd0, 0,8'hA5,8'h00);
    tbl[8]  = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 0,8'hA5,8'h3C);
    tbl[9]  = mk(0,0,1,2'd1,8'h77,2'd1,2'd1, 0,8'h77,8'h77); // bypass
    tbl[10] = mk(0,0,0,2'd0,8'h00,2'd1,2'd1, 0,8'h77,8'h77);
    tbl[11] = mk(0,0,1,2'd0,8'h11,2'd0,2'd1, 0,8'h11,8'h77);
    tbl[12] = mk(0,1,1,2'd2,8'hEE,2'd2,2'd0, 0,8'hA5,8'h11); // clr kills write and bypass
    tbl[13] = mk(0,0,1,2'd2,8'h99,2'd2,2'd0, 1,8'h00,8'h00);
    tbl[14] = mk(0,1,0,2'd0,8'h00,2'd2,2'd3, 1,8'h00,8'h00);
    tbl[15] = mk(0,0,1,2'd3,8'h44,2'd2,2'd3, 1,8'h00,8'h00);
    tbl[16] = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 1,8'h00,8'h00);
    tbl[17] = mk(0,0,0,2'd0,8'h00,2'd2,2'd3, 0,8'h00,8'h00);
    tbl[18] = mk(0,0,0,2'd0,8'h00,2'd0,2'd1, 0,8'h00,8'h00);

    // Single reset cycle; outputs before the first edge are undefined.
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; w_addr = '0; w_data = '0; r0_addr = '0; r1_addr = '0;
    #1;
    tick();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rs, tbl[i].c, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra0, tbl[i].ra1);
      chk($sformatf("tbl%0d_busy", i), a_busy, tbl[i].eb);
      chk($sformatf("tbl%0d_r0", i), a_r0, tbl[i].e0);
      chk($sformatf("tbl%0d_r1", i), a_r1, tbl[i].e1);
      if (i == 9) chk("nobypass_r0", n_r0, 8'h00);
      tick();
    end

    // Fill with 0xFF, then clr together with a write: write dropped, 4-cycle sweep.
    for (int a = 0; a < N; a++) begin
      drive(0, 0, 1, a[1:0], 8'hFF, 2'd0, 2'd0);
      tick();
    end
    drive(0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd3);
    chk("fill_r0", a_r0, 8'hFF);
    chk("fill_r1", a_r1, 8'hFF);
    tick();
    drive(0, 1, 1, 2'd0, 8'h11, 2'd0, 2'd1);
    chk("clr_nobypass", a_r0, 8'hFF);
    tick();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, k[1:0], 8'h22, 2'd0, 2'd1);
      if (!a_busy) break;
      cnt++;
      tick();
    end
    chk("clr_len", cnt, 4);
    for (int a = 0; a < N; a++) begin
      drive(0, 0, 0, 2'd0, 8'h00, a[1:0], a[1:0]);
      chk($sformatf("after_clr%0d", a), a_r0, 8'h00);
      tick();
    end

    // Reset mid-sweep at ptr=2, held 3 cycles; the sweep restarts after release.
    drive(0, 0, 1, 2'd3, 8'h5C, 2'd0, 2'd0);
    tick();
    drive(0, 1, 0, 2'd0, 8'h00, 2'd0, 2'd0);
    tick();
    for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 2'd0, 8'h00, 2'd3, 2'd3); tick(); end
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 2'd1, 8'hAB, 2'd3, 2'd1);
      chk($sformatf("rst_busy%0d", k), a_busy, 1'b1);
      tick();
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(0, k == 1, 0, 2'd0, 8'h00, 2'd3, 2'd1);
      if (!a_busy) break;
      cnt++;
      tick();
    end
    chk("rst_restart_len", cnt, 4);
    tick();

    // Hardwired-zero entry 0 on the R0_ZERO instance.
    drive(0, 0, 1, 2'd0, 8'h5A, 2'd0, 2'd0);
    chk("z_bypass0", z_r0, 8'h00);
    chk("a_bypass0", a_r0, 8'h5A);
    tick();
    drive(0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd0);
    chk("z_read0", z_r0, 8'h00);
    tick();
    drive(0, 0, 1, 2'd1, 8'h5A, 2'd1, 2'd1);
    chk("z_bypass1", z_r1, 8'h5A);
    tick();
    drive(0, 0, 0, 2'd0, 8'h00, 2'd1, 2'd0);
    chk("z_read1", z_r0, 8'h5A);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 50) == 0, ($urandom % 12) == 0, $urandom % 2,
            2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
      tick();
    end
    drive(0, 0, 0, 2'd0, 8'h00, 2'd0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
